// File: rtl/cpu0_oci_pkg.sv
// cpu0_oci_pkg: shared widths and FSM state for the DCT trace atom packer.
package cpu0_oci_pkg;
   localparam int DCT_BUF_W     = 30;
   localparam int DCT_CNT_W     = 4;
   localparam int DCT_MAX_ATOMS = 15;
   localparam int ATOM_W        = 2;
   localparam int WORD_W        = DCT_CNT_W + DCT_BUF_W;
   typedef enum logic [1:0] {IDLE, FILL, EMIT} dct_state_e;
endpackage

// File: rtl/cpu0_oci_dct_outreg.sv
// cpu0_oci_dct_outreg: valid/ready holding register for one packed trace word.
module cpu0_oci_dct_outreg
   import cpu0_oci_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [WORD_W-1:0] din,
   input  logic              word_ready,
   output logic              word_valid,
   output logic [WORD_W-1:0] word_data
);
   logic              valid_q, valid_d;
   logic [WORD_W-1:0] data_q, data_d;
   always_comb begin
      valid_d = load ? 1'b1 : (valid_q && word_ready) ? 1'b0 : valid_q;
      data_d  = load ? din : data_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end
   assign word_valid = valid_q;
   assign word_data  = data_q;
endmodule

// File: rtl/cpu0_oci_dct_sequencer.sv
// cpu0_oci_dct_sequencer: packs 2-bit trace atoms into 34-bit {count, buffer} words.
// Define CPU0_OCI_DCT_OVERFLOW_EN for drop mode with overflow/lost_count reporting.
module cpu0_oci_dct_sequencer
   import cpu0_oci_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 trace_en,
   input  logic                 atom_valid,
   input  logic [ATOM_W-1:0]    atom,
   output logic                 atom_ready,
   input  logic                 flush,
   output logic                 word_valid,
   output logic [WORD_W-1:0]    word_data,
   input  logic                 word_ready,
   output logic [DCT_BUF_W-1:0] dct_buffer,
   output logic [DCT_CNT_W-1:0] dct_count,
`ifdef CPU0_OCI_DCT_OVERFLOW_EN
   output logic                 overflow,
   output logic [7:0]           lost_count,
   input  logic                 overflow_clr,
`endif
   output logic                 busy
);
   dct_state_e           state_q, state_d;
   logic [DCT_BUF_W-1:0] dbuf_q, dbuf_d, dbuf_n;
   logic [DCT_CNT_W-1:0] cnt_q, cnt_d, cnt_n;
   logic                 acc, go_emit, hs;
`ifdef CPU0_OCI_DCT_OVERFLOW_EN
   assign atom_ready = reset_n && trace_en;
`else
   assign atom_ready = reset_n && trace_en && (state_q != EMIT);
`endif
   // In drop mode atom_ready stays high in EMIT, so acceptance also excludes EMIT.
   assign acc = atom_valid && atom_ready && (state_q != EMIT);
   assign hs  = word_valid && word_ready;
   always_comb begin
      dbuf_n  = acc ? {dbuf_q[DCT_BUF_W-ATOM_W-1:0], atom} : dbuf_q;
      cnt_n   = acc ? cnt_q + 1'b1 : cnt_q;
      go_emit = (acc && cnt_q == DCT_CNT_W'(DCT_MAX_ATOMS - 1)) || (flush && state_q == FILL);
      state_d = (state_q == EMIT) ? (hs ? IDLE : EMIT) :
                go_emit ? EMIT : (cnt_n != '0) ? FILL : IDLE;
      dbuf_d  = hs ? '0 : dbuf_n;
      cnt_d   = hs ? '0 : cnt_n;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         dbuf_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dbuf_q  <= dbuf_d;
         cnt_q   <= cnt_d;
      end
   end
   cpu0_oci_dct_outreg u_outreg (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (go_emit && state_q != EMIT),
      .din        ({cnt_n, dbuf_n}),
      .word_ready (word_ready),
      .word_valid (word_valid),
      .word_data  (word_data)
   );
`ifdef CPU0_OCI_DCT_OVERFLOW_EN
   logic       ovf_q, ovf_d, drop;
   logic [7:0] lost_q, lost_d;
   always_comb begin
      drop   = atom_valid && atom_ready && (state_q == EMIT);
      ovf_d  = overflow_clr ? drop : (ovf_q || drop);
      lost_d = overflow_clr ? {7'd0, drop} : (drop && lost_q != 8'hFF) ? lost_q + 8'd1 : lost_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q  <= 1'b0;
         lost_q <= '0;
      end else begin
         ovf_q  <= ovf_d;
         lost_q <= lost_d;
      end
   end
   assign overflow   = ovf_q;
   assign lost_count = lost_q;
`endif
   assign dct_buffer = dbuf_q;
   assign dct_count  = cnt_q;
   assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_cpu0_oci_dct_sequencer.sv
// tb_cpu0_oci_dct_sequencer: directed checks of packing, flush, backpressure and reset.
// Overflow checks are compiled only when CPU0_OCI_DCT_OVERFLOW_EN is defined.
module tb_cpu0_oci_dct_sequencer;
   logic        clk = 1'b0;
   logic        reset_n, trace_en, atom_valid, flush, word_ready;
   logic [1:0]  atom;
   logic        atom_ready, word_valid, busy;
   logic [33:0] word_data, held;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   int          total = 0, bad = 0;
`ifdef CPU0_OCI_DCT_OVERFLOW_EN
   logic        overflow, overflow_clr;
   logic [7:0]  lost_count;
   localparam logic EMIT_READY = 1'b1;
`else
   localparam logic EMIT_READY = 1'b0;
`endif
   cpu0_oci_dct_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .trace_en   (trace_en),
      .atom_valid (atom_valid),
      .atom       (atom),
      .atom_ready (atom_ready),
      .flush      (flush),
      .word_valid (word_valid),
      .word_data  (word_data),
      .word_ready (word_ready),
      .dct_buffer (dct_buffer),
      .dct_count  (dct_count),
`ifdef CPU0_OCI_DCT_OVERFLOW_EN
      .overflow     (overflow),
      .lost_count   (lost_count),
      .overflow_clr (overflow_clr),
`endif
      .busy       (busy)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic put(input logic [1:0] a);
      atom_valid = 1'b1;
      atom = a;
      step();
      atom_valid = 1'b0;
   endtask
   task automatic handshake();
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
   endtask
   initial begin
      reset_n = 1'b0; trace_en = 1'b1; atom_valid = 1'b1; atom = 2'b01;
      flush = 1'b0; word_ready = 1'b0;
`ifdef CPU0_OCI_DCT_OVERFLOW_EN
      overflow_clr = 1'b0;
`endif
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_count", dct_count, 0);
      chk("rst_buffer", dct_buffer, 0);
      chk("rst_valid", word_valid, 0);
      chk("rst_data", word_data, 0);
      chk("rst_ready", atom_ready, 0);
      atom_valid = 1'b0;
      reset_n = 1'b1;
      step();
      // full word of 15 x 2'b01, atom_valid kept high into EMIT
      atom_valid = 1'b1; atom = 2'b01;
      for (int i = 0; i < 14; i++) step();
      chk("fill14_valid", word_valid, 0);
      chk("fill14_count", dct_count, 14);
      step();
      chk("full_valid", word_valid, 1);
      chk("full_data", word_data, {4'hF, 30'h15555555});
      chk("full_ready", atom_ready, EMIT_READY);
      chk("full_busy", busy, 1);
      held = word_data;
      for (int i = 0; i < 5; i++) step();
      chk("bp_valid", word_valid, 1);
      chk("bp_data", word_data, held);
      chk("bp_count", dct_count, 15);
      chk("bp_buffer", dct_buffer, 30'h15555555);
      atom_valid = 1'b0;
      handshake();
      chk("hs1_valid", word_valid, 0);
      chk("hs1_count", dct_count, 0);
      chk("hs1_buffer", dct_buffer, 0);
      chk("hs1_busy", busy, 0);
      // partial flush
      put(2'b11); put(2'b10); put(2'b01);
      chk("part_count", dct_count, 3);
      chk("part_noword", word_valid, 0);
      flush = 1'b1; step(); flush = 1'b0;
      chk("part_valid", word_valid, 1);
      chk("part_data", word_data, {4'd3, 30'h00000039});
      handshake();
      chk("part_count0", dct_count, 0);
      chk("part_idle", busy, 0);
      // flush in IDLE ignored
      flush = 1'b1; step(); flush = 1'b0;
      chk("idleflush_valid", word_valid, 0);
      chk("idleflush_busy", busy, 0);
      // flush coinciding with 4th atom
      put(2'b00); put(2'b01); put(2'b10);
      flush = 1'b1; put(2'b11); flush = 1'b0;
      chk("coin_valid", word_valid, 1);
      chk("coin_data", word_data, {4'd4, 30'h0000001B});
      handshake();
      chk("coin_count0", dct_count, 0);
      // trace_en low: retain atoms, flush still works
      put(2'b10); put(2'b01);
      trace_en = 1'b0;
      atom_valid = 1'b1; atom = 2'b11;
      step(); step();
      chk("ten_ready", atom_ready, 0);
      chk("ten_count", dct_count, 2);
      chk("ten_buffer", dct_buffer, 30'h9);
      atom_valid = 1'b0;
      flush = 1'b1; step(); flush = 1'b0;
      chk("ten_data", word_data, {4'd2, 30'h9});
      chk("ten_valid", word_valid, 1);
      handshake();
      chk("ten_hs_count", dct_count, 0);
      trace_en = 1'b1;
      // reset mid-EMIT
      put(2'b11); put(2'b11);
      flush = 1'b1; step(); flush = 1'b0;
      chk("pre_rst_valid", word_valid, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", word_valid, 0);
      chk("mid_rst_count", dct_count, 0);
      chk("mid_rst_busy", busy, 0);
      step();
      reset_n = 1'b1;
      step();
      chk("post_rst_valid", word_valid, 0);
`ifdef CPU0_OCI_DCT_OVERFLOW_EN
      put(2'b01);
      flush = 1'b1; step(); flush = 1'b0;
      atom_valid = 1'b1; atom = 2'b10;
      step(); step();
      atom_valid = 1'b0;
      chk("ovf_flag", overflow, 1);
      chk("ovf_lost", lost_count, 2);
      chk("ovf_word", word_data, {4'd1, 30'h1});
      overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
      chk("ovf_clr_flag", overflow, 0);
      chk("ovf_clr_lost", lost_count, 0);
      atom_valid = 1'b1; overflow_clr = 1'b1; step();
      atom_valid = 1'b0; overflow_clr = 1'b0;
      chk("ovf_coin_lost", lost_count, 1);
      handshake();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
